// File: rtl/mem_access_controller.sv
// Memory-path sequencer: arbitrates fetch vs. data requests and steps the MAR/MDR/IR/TEMP/RAM strobes.
// Optional timeout fault on a missing MFC is enabled by defining MEM_TIMEOUT_EN.
module mem_access_controller #(
   parameter int TIMEOUT = 16
) (
   input  logic       Clk,
   input  logic       Clr,
   input  logic       fetch_req,
   input  logic       data_req,
   input  logic       data_write,
   input  logic [1:0] data_size,
   input  logic       data_signed,
   input  logic       MFC,
   output logic       fetch_done,
   output logic       data_done,
   output logic       mem_fault,
   output logic       busy,
   output logic       MAR_Enable,
   output logic       MDR_Enable,
   output logic       MDR_Mux_select,
   output logic       IR_Enable,
   output logic       TEMP_Enable,
   output logic       RAM_enable,
   output logic [5:0] RAM_OpCode
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_ACCESS,
      S_CAPTURE,
      S_DONE
`ifdef MEM_TIMEOUT_EN
      , S_FAULT
`endif
   } state_t;

   state_t     state_q, state_d;
   logic       gnt_data_q, gnt_data_d;
   logic [5:0] op_sel;
   logic       timeout_hit;

   // Fetches are always word reads; data accesses carry the requester's attributes.
   assign op_sel = gnt_data_q ? {2'b00, data_signed, data_write, data_size} : 6'b000010;

`ifdef MEM_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Terminal ACCESS cycle: this is the TIMEOUT-th cycle spent waiting.
   assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (state_d == S_ACCESS && state_q != S_ACCESS) begin
         cnt_d = '0;
      end else if (state_q == S_ACCESS && !MFC) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge Clk or negedge Clr) begin
      if (!Clr) begin
         state_q    <= S_IDLE;
         gnt_data_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_data_q <= gnt_data_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      gnt_data_d     = gnt_data_q;
      fetch_done     = 1'b0;
      data_done      = 1'b0;
      mem_fault      = 1'b0;
      busy           = (state_q != S_IDLE);
      MAR_Enable     = 1'b0;
      MDR_Enable     = 1'b0;
      MDR_Mux_select = 1'b0;
      IR_Enable      = 1'b0;
      TEMP_Enable    = 1'b0;
      RAM_enable     = 1'b0;
      RAM_OpCode     = 6'b000000;

      case (state_q)
         S_IDLE: begin
            if (data_req) begin
               gnt_data_d = 1'b1;
               state_d    = S_ADDR;
            end else if (fetch_req) begin
               gnt_data_d = 1'b0;
               state_d    = S_ADDR;
            end
         end
         S_ADDR: begin
            MAR_Enable = 1'b1;
            state_d    = (gnt_data_q && data_write) ? S_WDATA : S_ACCESS;
         end
         S_WDATA: begin
            MDR_Enable = 1'b1;
            state_d    = S_ACCESS;
         end
         S_ACCESS: begin
            RAM_enable = 1'b1;
            RAM_OpCode = op_sel;
            // A late MFC in the terminal cycle still wins over the timeout.
            if (MFC) begin
               state_d = (gnt_data_q && data_write) ? S_DONE : S_CAPTURE;
            end else if (timeout_hit) begin
`ifdef MEM_TIMEOUT_EN
               state_d = S_FAULT;
`endif
            end
         end
         S_CAPTURE: begin
            RAM_enable = 1'b1;
            RAM_OpCode = op_sel;
            if (gnt_data_q) begin
               MDR_Enable     = 1'b1;
               MDR_Mux_select = 1'b1;
               TEMP_Enable    = 1'b1;
            end else begin
               IR_Enable = 1'b1;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            data_done  = gnt_data_q;
            fetch_done = !gnt_data_q;
            state_d    = S_IDLE;
         end
`ifdef MEM_TIMEOUT_EN
         S_FAULT: begin
            mem_fault  = 1'b1;
            data_done  = gnt_data_q;
            fetch_done = !gnt_data_q;
            state_d    = S_IDLE;
         end
`endif
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_controller.sv
// Self-checking bench for mem_access_controller: per-cycle output schedules derived from access timing rules.
// Build with MEM_TIMEOUT_EN defined to exercise the timeout fault path (TIMEOUT is set to 4 here).
module tb_mem_access_controller;

   localparam int TMO = 4;

   logic       Clk = 1'b0;
   logic       Clr = 1'b0;
   logic       fetch_req = 1'b0;
   logic       data_req = 1'b0;
   logic       data_write = 1'b0;
   logic [1:0] data_size = 2'b00;
   logic       data_signed = 1'b0;
   logic       MFC = 1'b0;
   logic       fetch_done, data_done, mem_fault, busy;
   logic       MAR_Enable, MDR_Enable, MDR_Mux_select, IR_Enable, TEMP_Enable, RAM_enable;
   logic [5:0] RAM_OpCode;

   int n_checks = 0;
   int n_fail   = 0;

   mem_access_controller #(.TIMEOUT(TMO)) dut (
      .Clk(Clk), .Clr(Clr),
      .fetch_req(fetch_req), .data_req(data_req),
      .data_write(data_write), .data_size(data_size), .data_signed(data_signed),
      .MFC(MFC),
      .fetch_done(fetch_done), .data_done(data_done), .mem_fault(mem_fault), .busy(busy),
      .MAR_Enable(MAR_Enable), .MDR_Enable(MDR_Enable), .MDR_Mux_select(MDR_Mux_select),
      .IR_Enable(IR_Enable), .TEMP_Enable(TEMP_Enable),
      .RAM_enable(RAM_enable), .RAM_OpCode(RAM_OpCode)
   );

   always #5 Clk = ~Clk;

   // {fetch_done,data_done,mem_fault,busy,MAR,MDR,MUX,IR,TEMP,RAM_en,opcode[5:0]}
   logic [15:0] obs;
   assign obs = {fetch_done, data_done, mem_fault, busy, MAR_Enable, MDR_Enable,
                 MDR_Mux_select, IR_Enable, TEMP_Enable, RAM_enable, RAM_OpCode};

   // Expected outputs in cycle c of one access (cycle 0 = IDLE cycle where the request is seen).
   function automatic logic [15:0] expv(int c, bit d, bit wr, logic [1:0] sz, bit sg,
                                        int acc_len, bit flt);
      logic [15:0] v;
      logic [5:0]  op;
      bit          st;
      int          acc_s, acc_e;
      v     = '0;
      st    = d && wr;
      acc_s = st ? 3 : 2;
      acc_e = acc_s + acc_len - 1;
      op    = d ? {2'b00, sg, wr, sz} : 6'b000010;
      if (c == 0) return v;
      v[12] = 1'b1;
      if (c == 1) begin
         v[11] = 1'b1;
      end else if (st && c == 2) begin
         v[10] = 1'b1;
      end else if (c >= acc_s && c <= acc_e) begin
         v[6]   = 1'b1;
         v[5:0] = op;
      end else if (flt && c == acc_e + 1) begin
         v[13] = 1'b1;
         if (d) v[14] = 1'b1; else v[15] = 1'b1;
      end else if (!st && c == acc_e + 1) begin
         v[6]   = 1'b1;
         v[5:0] = op;
         if (d) begin
            v[10] = 1'b1; v[9] = 1'b1; v[7] = 1'b1;
         end else begin
            v[8] = 1'b1;
         end
      end else begin
         if (d) v[14] = 1'b1; else v[15] = 1'b1;
      end
      return v;
   endfunction

   // Entry: just after a rising edge, DUT about to be IDLE. Exit: just after the edge ending DONE/FAULT.
   task automatic do_txn(input string name, input bit d, input bit wr, input logic [1:0] sz,
                         input bit sg, input int wait_cyc, input bit flt, input bit keep_fetch);
      int acc_len, acc_s, total, nerr;
      logic [15:0] e, mask;
      nerr    = 0;
      acc_len = flt ? TMO : wait_cyc + 1;
      acc_s   = (d && wr) ? 3 : 2;
      total   = (flt || (d && wr)) ? acc_s + acc_len : acc_s + acc_len + 1;
      if (d) begin
         data_req = 1'b1; data_write = wr; data_size = sz; data_signed = sg;
      end else begin
         fetch_req = 1'b1;
      end
      MFC = 1'b0;
      for (int c = 0; c <= total; c++) begin
         if (c > 0) begin
            @(posedge Clk); #1;
            MFC = (!flt && c == acc_s + acc_len - 1);
         end
         @(negedge Clk);
         e    = expv(c, d, wr, sz, sg, acc_len, flt);
         mask = (e[6] || c == 0) ? 16'hFFFF : 16'hFFC0;
         n_checks++;
         if ((obs & mask) !== e) begin
            n_fail++; nerr++;
            $display("FAIL %s cycle %0d: outputs %b, required %b (mask %h)", name, c, obs, e, mask);
         end
      end
      @(posedge Clk); #1;
      MFC = 1'b0;
      if (d) data_req = 1'b0;
      if (!keep_fetch) fetch_req = 1'b0;
      $display("txn %-10s data=%0d wr=%0d size=%0d sgn=%0d wait=%0d fault=%0d cycles=%0d errors=%0d",
               name, d, wr, sz, sg, wait_cyc, flt, total, nerr);
   endtask

   task automatic test_reset();
      Clr = 1'b0;
      #12;
      n_checks++;
      if (obs !== 16'h0000) begin
         n_fail++; $display("FAIL reset_hold: outputs %b, required 0", obs);
      end
      @(posedge Clk); #1;
      Clr = 1'b1;
      repeat (2) begin
         @(negedge Clk);
         n_checks++;
         if (obs !== 16'h0000) begin
            n_fail++; $display("FAIL reset_idle: outputs %b, required 0", obs);
         end
      end
      @(posedge Clk); #1;
   endtask

   task automatic test_reset_mid_access();
      fetch_req = 1'b1;
      MFC       = 1'b0;
      repeat (3) @(posedge Clk);
      #2;
      n_checks++;
      if (!(RAM_enable === 1'b1 && busy === 1'b1 && RAM_OpCode === 6'b000010)) begin
         n_fail++; $display("FAIL mid_access_pre: outputs %b, required RAM_enable busy op 000010", obs);
      end
      Clr = 1'b0;
      #1;
      n_checks++;
      if (obs !== 16'h0000) begin
         n_fail++; $display("FAIL mid_access_reset: outputs %b, required 0", obs);
      end
      fetch_req = 1'b0;
      @(posedge Clk); #1;
      Clr = 1'b1;
      repeat (3) begin
         @(negedge Clk);
         n_checks++;
         if (obs !== 16'h0000) begin
            n_fail++; $display("FAIL mid_access_after: outputs %b, required 0 (no done pulse)", obs);
         end
      end
      @(posedge Clk); #1;
      $display("txn reset_mid abandoned fetch in ACCESS");
   endtask

   task automatic test_fetch_delayed();
      do_txn("fetch_w3", 1'b0, 1'b0, 2'b00, 1'b0, 3, 1'b0, 1'b0);
   endtask

   task automatic test_byte_signed_load();
      do_txn("ldb_sgn", 1'b1, 1'b0, 2'b00, 1'b1, 0, 1'b0, 1'b0);
   endtask

   task automatic test_word_store();
      do_txn("stw", 1'b1, 1'b1, 2'b10, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_simultaneous();
      fetch_req = 1'b1;
      do_txn("simul_data", 1'b1, 1'b0, 2'b10, 1'b0, 0, 1'b0, 1'b1);
      do_txn("simul_fetch", 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b0, 1'b0);
   endtask

   task automatic test_long_wait();
`ifdef MEM_TIMEOUT_EN
      do_txn("fetch_tmo", 1'b0, 1'b0, 2'b00, 1'b0, 0, 1'b1, 1'b0);
      do_txn("ld_tmo", 1'b1, 1'b0, 2'b01, 1'b0, 0, 1'b1, 1'b0);
      do_txn("ld_late", 1'b1, 1'b0, 2'b01, 1'b1, TMO - 1, 1'b0, 1'b0);
      do_txn("st_late", 1'b1, 1'b1, 2'b00, 1'b0, TMO - 1, 1'b0, 1'b0);
`else
      do_txn("fetch_w20", 1'b0, 1'b0, 2'b00, 1'b0, 20, 1'b0, 1'b0);
      do_txn("st_w12", 1'b1, 1'b1, 2'b01, 1'b1, 12, 1'b0, 1'b0);
`endif
   endtask

   task automatic test_back_to_back_random();
      bit d, wr, sg;
      logic [1:0] sz;
      int w;
      for (int i = 0; i < 24; i++) begin
         d  = 1'($urandom_range(0, 1));
         wr = 1'($urandom_range(0, 1));
         sg = 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 2));
         w  = $urandom_range(0, 3);
         do_txn("random", d, wr, sz, sg, w, 1'b0, 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_fetch_delayed();
      test_byte_signed_load();
      test_word_store();
      test_simultaneous();
      test_reset_mid_access();
      test_long_wait();
      test_back_to_back_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
